regwrite_queue: RTL and testbench
=================================

# regwrite_queue

Write-side front end for the 64 x 32-bit register file: buffers writeback results from the pipeline in a small FIFO and drains them, one per cycle, onto the register file's single write port (rd/din/wrt). Sits between the writeback stage and the register file. Provides a youngest-first bypass lookup on the two read addresses (rs, rt) so decode sees values that are still queued and not yet written.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  writeback result offered
- in_ready  out  1  queue can accept; push occurs when in_valid && in_ready
- in_rd  in  6  destination register number
- in_data  in  32  value to write
- drain_en  in  1  write port available this cycle; gates pops
- rd  out  6  register file write address (registered)
- din  out  32  register file write data (registered)
- wrt  out  1  register file write enable (registered, one-cycle pulse per entry)
- rs  in  6  bypass query address A
- rt  in  6  bypass query address B
- s_hit  out  1  pending write to rs exists
- s_data  out  32  youngest pending value for rs
- t_hit  out  1  pending write to rt exists
- t_data  out  32  youngest pending value for rt
- empty  out  1  queue empty and no write in flight (wrt low)

## Operation
- Circular FIFO: DEPTH entries of {rd[5:0], data[31:0]}, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- in_ready = (count < DEPTH); combinational from count only; no push-through when full, even if a pop happens the same cycle.
- Pop when count > 0 && drain_en: head entry loaded into rd/din, wrt set to 1 next cycle; head advances.
- No pop in a cycle: wrt = 0 next cycle; rd/din hold last value.
- Push and pop in same cycle: count unchanged, both pointers advance.
- Entries drain strictly in push order; multiple entries with same rd all issue (no coalescing).
- Register 0 receives no special treatment; it queues and bypasses like any other.
- Bypass search set: all valid FIFO entries plus the output register when wrt = 1. Youngest match wins: newest FIFO entry (nearest tail) first, output register last. No match -> hit = 0, data = 0.
- Bypass is combinational from registered state and rs/rt; the same-cycle incoming push is not visible.
- empty = (count == 0) && !wrt.

## Timing
- Reset (rst = 1 at rising edge): count = 0, head = tail = 0, wrt = 0, rd = 0, din = 0; in_ready = 1, empty = 1, s_hit = t_hit = 0, s_data = t_data = 0 in the following cycle. Pending entries and any in-flight write are discarded; a write presented as wrt in the reset cycle is dropped (wrt forced to 0).
- rst dominates in_valid and drain_en in the same cycle.
- Latency, empty queue with drain_en = 1: push at edge N, pop at edge N+1, wrt = 1 during cycle after edge N+1; register file commits at edge N+2.
- Throughput: one write per cycle sustained while drain_en = 1 and count > 0.
- drain_en low stalls drain indefinitely without loss; wrt drops to 0 after one cycle.
- Full (count == DEPTH): in_ready = 0; in_valid ignored; in_valid held by producer until accepted.
- Pointer wrap: entry at index DEPTH-1 followed by index 0 with no gap or reorder.

## Test plan
- Reset then push {rd=5, data=0x0000_00AA} with drain_en=1 -> wrt=1, rd=5, din=0xAA exactly two cycles after push edge; empty=1 the cycle after.
- drain_en=0, push rd=3 values 0x11, 0x22, 0x33, 0x44 -> in_ready=0 after 4th; 5th in_valid not accepted; rs=3 gives s_hit=1, s_data=0x44.
- From full, raise drain_en -> four consecutive wrt pulses with din 0x11, 0x22, 0x33, 0x44 in order; s_data tracks youngest remaining, 0x44 until the last write leaves the output register, then s_hit=0.
- Continuous push/pop for 10 entries (rd=i, data=0x100+i) with drain_en=1 -> count stays ≤1, pointers wrap, wrt sequence matches push order, no drops.
- Fill with 3 entries, assert rst mid-drain -> next cycle wrt=0, empty=1, in_ready=1, no further writes; rt pointing at queued rd gives t_hit=0.
- Simultaneous push and pop at count=DEPTH-1 -> count unchanged, in_ready stays 1, pushed value bypassable on t_data the next cycle.

Source files
------------

// File: rtl/regwrite_queue.sv
// regwrite_queue: buffers writeback results in a small circular FIFO and
// drains them one per cycle onto the register file's single write port.
// Also offers a youngest-first bypass lookup on the two decode read
// addresses so decode can see values that are queued but not yet written.
module regwrite_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_rd,
    input  logic [31:0] in_data,
    input  logic        drain_en,
    output logic [5:0]  rd,
    output logic [31:0] din,
    output logic        wrt,
    input  logic [5:0]  rs,
    input  logic [5:0]  rt,
    output logic        s_hit,
    output logic [31:0] s_data,
    output logic        t_hit,
    output logic [31:0] t_data,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [5:0]  r_memRd   [DEPTH];
    logic [31:0] r_memData [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;
    logic [AW-1:0] w_idx;

    // Acceptance depends on occupancy alone, so a full queue refuses a push
    // even when an entry leaves in the same cycle.
    assign in_ready = (r_count != FULL_COUNT);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && drain_en;
    assign empty    = (r_count == '0) && !wrt;

    // Entry storage needs no reset: occupancy tracking decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memRd[r_tail]   <= in_rd;
            r_memData[r_tail] <= in_data;
        end
    end

    // Pointers, occupancy and the registered write port; reset discards
    // everything, including a write currently being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            wrt     <= 1'b0;
            rd      <= '0;
            din     <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                rd     <= r_memRd[r_head];
                din    <= r_memData[r_head];
                wrt    <= 1'b1;
                r_head <= r_head + 1'b1;
            end else begin
                wrt    <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bypass lookup: start from the in-flight write, then walk FIFO entries
    // oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        s_hit  = wrt && (rd == rs);
        s_data = (wrt && (rd == rs)) ? din : 32'h0;
        t_hit  = wrt && (rd == rt);
        t_data = (wrt && (rd == rt)) ? din : 32'h0;
        w_idx  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if (r_memRd[w_idx] == rs) begin
                    s_hit  = 1'b1;
                    s_data = r_memData[w_idx];
                end
                if (r_memRd[w_idx] == rt) begin
                    t_hit  = 1'b1;
                    t_data = r_memData[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regwrite_queue.sv
// Testbench for regwrite_queue: a table of per-cycle vectors, a few
// hand-written corner sequences, and a scoreboard model that tracks every
// accepted entry and checks write order, flags and bypass results.
module tb_regwrite_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en;
    logic [5:0]  rd;
    logic [31:0] din;
    logic        wrt;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic        s_hit;
    logic [31:0] s_data;
    logic        t_hit;
    logic [31:0] t_data;
    logic        empty;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [5:0]  rd;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [5:0]  ird;
        logic [31:0] idat;
        logic        de;
        logic [5:0]  rs;
        logic        chk;
        logic        eReady;
        logic        eEmpty;
        logic        eWrt;
        logic        eSHit;
        logic [31:0] eSData;
        logic [5:0]  eRd;
        logic [31:0] eDin;
    } vec_t;

    entry_t sbq[$];
    int     mCount  = 0;
    logic   expWrt  = 1'b0;
    logic   armed   = 1'b0;
    int     wrtSeen = 0;

    regwrite_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en),
        .rd(rd), .din(din), .wrt(wrt),
        .rs(rs), .rt(rt),
        .s_hit(s_hit), .s_data(s_data),
        .t_hit(t_hit), .t_data(t_data),
        .empty(empty)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and return just after the following rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [5:0] ird,
                                 input logic [31:0] idat, input logic de,
                                 input logic [5:0] a, input logic [5:0] b);
        rst      = r;
        in_valid = v;
        in_rd    = ird;
        in_data  = idat;
        drain_en = de;
        rs       = a;
        rt       = b;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic void modelLookup(input logic [5:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'h0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].rd == a) begin
                hit = 1'b1;
                d   = sbq[i].data;
                break;
            end
        end
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [5:0] ird,
                                input logic [31:0] idat, input logic de, input logic [5:0] a,
                                input logic c, input logic eReady, input logic eEmpty,
                                input logic eWrt, input logic eSHit, input logic [31:0] eSData,
                                input logic [5:0] eRd, input logic [31:0] eDin);
        vec_t x;
        x.rst = r; x.iv = v; x.ird = ird; x.idat = idat; x.de = de; x.rs = a;
        x.chk = c; x.eReady = eReady; x.eEmpty = eEmpty; x.eWrt = eWrt;
        x.eSHit = eSHit; x.eSData = eSData; x.eRd = eRd; x.eDin = eDin;
        return x;
    endfunction

    // Reference model: tracks occupancy and pending entries at every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
            mCount = 0;
            expWrt = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            logic pushOk;
            logic popOk;
            entry_t e;
            pushOk = in_valid && (mCount < DEPTH);
            popOk  = (mCount > 0) && drain_en;
            if (pushOk) begin
                e.rd   = in_rd;
                e.data = in_data;
                sbq.push_back(e);
            end
            mCount = mCount + (pushOk ? 1 : 0) - (popOk ? 1 : 0);
            expWrt = popOk;
        end
    end

    // Scoreboard check mid-cycle: flags, bypass against pending entries, and
    // in-order delivery of each write on the port.
    always @(negedge clk) begin
        if (armed) begin
            logic hit;
            logic [31:0] d;
            entry_t e;
            checkOutput("sb_wrt", {31'h0, wrt}, {31'h0, expWrt});
            checkOutput("sb_in_ready", {31'h0, in_ready}, {31'h0, (mCount < DEPTH)});
            checkOutput("sb_empty", {31'h0, empty}, {31'h0, (mCount == 0) && !expWrt});
            modelLookup(rs, hit, d);
            checkOutput("sb_s_hit", {31'h0, s_hit}, {31'h0, hit});
            checkOutput("sb_s_data", s_data, d);
            modelLookup(rt, hit, d);
            checkOutput("sb_t_hit", {31'h0, t_hit}, {31'h0, hit});
            checkOutput("sb_t_data", t_data, d);
            if (expWrt && sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput("sb_rd", {26'h0, rd}, {26'h0, e.rd});
                checkOutput("sb_din", din, e.data);
                wrtSeen++;
            end
        end
    end

    initial begin
        vec_t tbl[17];
        int   base;

        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        drain_en = 1'b0; rs = '0; rt = '0;

        // Reset, single-entry latency, fill to full, then drain from full.
        tbl[0]  = mk(1,0,0,32'h00,0,0, 0, 0,0,0,0,32'h00, 0,32'h00);
        tbl[1]  = mk(0,1,5,32'hAA,1,5, 1, 1,1,0,0,32'h00, 0,32'h00);
        tbl[2]  = mk(0,0,0,32'h00,1,5, 1, 1,0,0,1,32'hAA, 0,32'h00);
        tbl[3]  = mk(0,0,0,32'h00,1,5, 1, 1,0,1,1,32'hAA, 5,32'hAA);
        tbl[4]  = mk(0,0,0,32'h00,0,5, 1, 1,1,0,0,32'h00, 5,32'hAA);
        tbl[5]  = mk(0,1,3,32'h11,0,3, 1, 1,1,0,0,32'h00, 5,32'hAA);
        tbl[6]  = mk(0,1,3,32'h22,0,3, 1, 1,0,0,1,32'h11, 5,32'hAA);
        tbl[7]  = mk(0,1,3,32'h33,0,3, 1, 1,0,0,1,32'h22, 5,32'hAA);
        tbl[8]  = mk(0,1,3,32'h44,0,3, 1, 1,0,0,1,32'h33, 5,32'hAA);
        tbl[9]  = mk(0,1,3,32'h55,0,3, 1, 0,0,0,1,32'h44, 5,32'hAA);
        tbl[10] = mk(0,1,3,32'h55,0,3, 1, 0,0,0,1,32'h44, 5,32'hAA);
        tbl[11] = mk(0,0,0,32'h00,1,3, 1, 0,0,0,1,32'h44, 5,32'hAA);
        tbl[12] = mk(0,0,0,32'h00,1,3, 1, 1,0,1,1,32'h44, 3,32'h11);
        tbl[13] = mk(0,0,0,32'h00,1,3, 1, 1,0,1,1,32'h44, 3,32'h22);
        tbl[14] = mk(0,0,0,32'h00,1,3, 1, 1,0,1,1,32'h44, 3,32'h33);
        tbl[15] = mk(0,0,0,32'h00,1,3, 1, 1,0,1,1,32'h44, 3,32'h44);
        tbl[16] = mk(0,0,0,32'h00,1,3, 1, 1,1,0,0,32'h00, 3,32'h44);

        for (int k = 0; k < 17; k++) begin
            rst = tbl[k].rst; in_valid = tbl[k].iv; in_rd = tbl[k].ird;
            in_data = tbl[k].idat; drain_en = tbl[k].de; rs = tbl[k].rs; rt = '0;
            @(negedge clk);
            if (tbl[k].chk) begin
                checkOutput($sformatf("vec%0d_in_ready", k), {31'h0, in_ready}, {31'h0, tbl[k].eReady});
                checkOutput($sformatf("vec%0d_empty", k), {31'h0, empty}, {31'h0, tbl[k].eEmpty});
                checkOutput($sformatf("vec%0d_wrt", k), {31'h0, wrt}, {31'h0, tbl[k].eWrt});
                checkOutput($sformatf("vec%0d_s_hit", k), {31'h0, s_hit}, {31'h0, tbl[k].eSHit});
                checkOutput($sformatf("vec%0d_s_data", k), s_data, tbl[k].eSData);
                checkOutput($sformatf("vec%0d_rd", k), {26'h0, rd}, {26'h0, tbl[k].eRd});
                checkOutput($sformatf("vec%0d_din", k), din, tbl[k].eDin);
            end
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a drain drops queued and in-flight writes.
        applyStimulus(0, 1, 7, 32'h70, 0, 0, 8);
        applyStimulus(0, 1, 8, 32'h80, 0, 0, 8);
        applyStimulus(0, 1, 9, 32'h90, 0, 0, 8);
        applyStimulus(0, 0, 0, 32'h0, 1, 0, 8);
        checkOutput("mid_drain_wrt", {31'h0, wrt}, 32'h1);
        checkOutput("mid_drain_t_hit", {31'h0, t_hit}, 32'h1);
        applyStimulus(1, 1, 8, 32'hAB, 1, 0, 8);
        checkOutput("rst_wrt", {31'h0, wrt}, 32'h0);
        checkOutput("rst_empty", {31'h0, empty}, 32'h1);
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_t_hit", {31'h0, t_hit}, 32'h0);
        checkOutput("rst_t_data", t_data, 32'h0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 1, 0, 8);
            checkOutput("post_rst_wrt", {31'h0, wrt}, 32'h0);
        end

        // Simultaneous push and pop at DEPTH-1 occupancy.
        for (int k = 0; k < DEPTH - 1; k++)
            applyStimulus(0, 1, 6'(10 + k), 32'hA10 + 32'(k), 0, 0, 0);
        applyStimulus(0, 1, 13, 32'hD13, 1, 0, 13);
        checkOutput("pp_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("pp_t_hit", {31'h0, t_hit}, 32'h1);
        checkOutput("pp_t_data", t_data, 32'hD13);
        checkOutput("pp_din", din, 32'hA10);
        for (int k = 0; k < DEPTH + 2; k++)
            applyStimulus(0, 0, 0, 32'h0, 1, 0, 0);

        // Continuous streaming: ten entries, pointers wrap, nothing dropped.
        base = wrtSeen;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 6'(i), 32'h100 + 32'(i), 1, 6'(i), 6'(i));
            checkOutput("stream_in_ready", {31'h0, in_ready}, 32'h1);
        end
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 0, 0, 32'h0, 1, 0, 0);
        checkOutput("stream_write_count", 32'(wrtSeen - base), 32'd10);

        // Random traffic over a small address range to exercise bypass priority.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                          6'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 2) != 0,
                          6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)));
        end
        for (int k = 0; k < DEPTH + 3; k++)
            applyStimulus(0, 0, 0, 32'h0, 1, 0, 0);
        checkOutput("final_pending", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
